// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte
// (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) using the full
// inhibit / request-to-send / bit-shift / ACK handshake.
// PS2_CLK and PS2_DAT are driven open-drain through active-high pull-low
// enables (ps2_clk_oe / ps2_dat_oe); the top level turns them into tri-states.
// The high phase of ps2_clk_oe (INHIBIT plus the one-cycle RTS overlap)
// lasts exactly INHIBIT_CYCLES clk cycles.
// Optional build macro: PS2_TX_RETRY_EN -- a failed transfer is re-attempted
// with the same byte up to MAX_RETRIES extra times before error is reported.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int unsigned CNT_W   = $clog2(INHIBIT_CYCLES);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned FRAME_W = 11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NACK    = 2'd2;

    // Reject configurations the counters cannot represent.
    if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || MAX_RETRIES > 255) begin : g_bad_cfg
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be >= 2, MAX_RETRIES <= 255");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK,
        ST_RELEASE,
        ST_FAIL
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   shift_q;
    logic [3:0]           bit_idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [TMO_W-1:0]     tmr_q;
    logic                 clk_oe_q;
    logic                 dat_oe_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;
    logic [1:0]           err_code_q;

    logic                 clk_s1_q;
    logic                 clk_s2_q;
    logic                 clk_prev_q;
    logic                 dat_s1_q;
    logic                 dat_s2_q;

    logic                 fe_c;
    logic                 tmo_c;
    logic                 inh_last_c;

`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RETRY_W-1:0]   retry_cnt_q;
`endif

    // Two-flop synchronizers on both raw pins plus a delayed copy of the
    // synced clock for falling-edge detection. Reset to the idle-high level
    // so a reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // Device clock falling edge, timeout terminal count, inhibit terminal count.
    assign fe_c       = clk_prev_q & ~clk_s2_q;
    assign tmo_c      = (tmr_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign inh_last_c = (cnt_q == CNT_W'(INHIBIT_CYCLES - 2));

    // Transfer sequencer: all line enables and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            cnt_q       <= '0;
            tmr_q       <= '0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_cnt_q <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (start) begin
                        // Frame LSB first: start 0, d0..d7, odd parity, stop 1.
                        shift_q    <= {1'b1, ~^data, data, 1'b0};
                        err_code_q <= ERR_NONE;
                        cnt_q      <= '0;
                        clk_oe_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                        retry_cnt_q <= '0;
`endif
                    end
                end

                ST_INHIBIT: begin
                    // Hold the clock low; on terminal count drive the start bit.
                    clk_oe_q <= 1'b1;
                    if (inh_last_c) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= ST_RTS;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_RTS: begin
                    // Data already low with clock low; release clock to hand over.
                    clk_oe_q  <= 1'b0;
                    bit_idx_q <= 4'd1;
                    tmr_q     <= '0;
                    state_q   <= ST_SEND;
                end

                ST_SEND: begin
                    if (fe_c) begin
                        dat_oe_q  <= ~shift_q[bit_idx_q];
                        bit_idx_q <= bit_idx_q + 4'd1;
                        tmr_q     <= '0;
                        if (bit_idx_q == 4'd10) begin
                            state_q <= ST_ACK;
                        end
                    end else if (tmo_c) begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_FAIL;
                    end else begin
                        tmr_q <= tmr_q + TMO_W'(1);
                    end
                end

                ST_ACK: begin
                    // Device answers on the clock after the stop bit.
                    if (fe_c) begin
                        tmr_q <= '0;
                        if (!dat_s2_q) begin
                            state_q <= ST_RELEASE;
                        end else begin
                            clk_oe_q   <= 1'b0;
                            dat_oe_q   <= 1'b0;
                            err_code_q <= ERR_NACK;
                            state_q    <= ST_FAIL;
                        end
                    end else if (tmo_c) begin
                        clk_oe_q   <= 1'b0;
                        dat_oe_q   <= 1'b0;
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_FAIL;
                    end else begin
                        tmr_q <= tmr_q + TMO_W'(1);
                    end
                end

                ST_RELEASE: begin
                    // Transfer is complete only once the device lets both lines go.
                    if (clk_s2_q && dat_s2_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (fe_c) begin
                        tmr_q <= '0;
                    end else if (tmo_c) begin
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= ST_FAIL;
                    end else begin
                        tmr_q <= tmr_q + TMO_W'(1);
                    end
                end

                ST_FAIL: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
                    // Silent re-attempt with the same frame while retries remain.
                    if (retry_cnt_q < RETRY_W'(MAX_RETRIES)) begin
                        retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
                        cnt_q       <= '0;
                        clk_oe_q    <= 1'b1;
                        state_q     <= ST_INHIBIT;
                    end else begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
`else
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
`endif
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model with a behavioural PS/2
// device that clocks the frame in, ACKs, NACKs or stays silent.
// Expected frames/outcomes are queued when a start is driven and popped
// when the transfer finishes. Honours PS2_TX_RETRY_EN for the retry count.
module tb_ps2_host_tx;

    localparam int unsigned INH     = 60;
    localparam int unsigned TMO     = 2000;
    localparam int unsigned RETRIES = 2;
    localparam int          HALF    = 40;
`ifdef PS2_TX_RETRY_EN
    localparam int          ATTEMPTS = RETRIES + 1;
`else
    localparam int          ATTEMPTS = 1;
`endif
    localparam int M_ACK  = 0;
    localparam int M_NACK = 1;
    localparam int M_TMO  = 2;
    localparam int M_RST5 = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    // Pulled-up open-drain lines: low if either side pulls.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (RETRIES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data       (data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    typedef struct packed {
        logic [10:0] frame;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Free-running event counters; tasks work on deltas.
    int   done_tot = 0;
    int   err_tot = 0;
    int   both_tot = 0;
    int   clk_oe_hi_tot = 0;
    int   inh_tot = 0;
    logic clk_oe_prev = 1'b0;

    always @(negedge clk) begin
        if (done) done_tot <= done_tot + 1;
        if (error) err_tot <= err_tot + 1;
        if (done && error) both_tot <= both_tot + 1;
        if (ps2_clk_oe) clk_oe_hi_tot <= clk_oe_hi_tot + 1;
        if (ps2_clk_oe && !clk_oe_prev) inh_tot <= inh_tot + 1;
        clk_oe_prev <= ps2_clk_oe;
    end

    // Device model: waits for request-to-send, then clocks the frame in,
    // sampling data on each rising clock edge.
    task automatic device(input int mode, output logic [10:0] cap, output bit ok);
        int t;
        cap = '0;
        ok  = 1'b1;
        t   = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < 2 * int'(INH + TMO)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2 * int'(INH + TMO)) begin
            ok = 1'b0;
            return;
        end
        cap[0] = ps2_dat_in;
        if (mode == M_TMO) return;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            if (mode == M_RST5 && i == 5) begin
                repeat (6) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            cap[i] = ps2_dat_in;
            repeat (HALF) @(negedge clk);
        end
        if (mode == M_ACK) dev_dat_low = 1'b1;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        vectors++; if (ps2_clk_oe !== 1'b0) begin miscompares++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
        vectors++; if (ps2_dat_oe !== 1'b0) begin miscompares++; $display("FAIL reset_dat_oe: got %b want 0", ps2_dat_oe); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0 || error !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got done=%b error=%b want 0 0", done, error); end
        vectors++; if (err_code !== 2'd0) begin miscompares++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
    endtask

    // One complete transfer with the given device behaviour.
    task automatic run_tx(input logic [7:0] d, input int mode, input string name);
        exp_t        e;
        exp_t        got;
        logic [10:0] cap;
        logic [10:0] cap_first;
        bit          ok;
        int          d0, e0, b0, c0, i0, t, n_dev;
        e.frame = {1'b1, ~^d, d, 1'b0};
        e.code  = (mode == M_ACK) ? 2'd0 : (mode == M_NACK) ? 2'd2 : 2'd1;
        exp_q.push_back(e);
        d0 = done_tot; e0 = err_tot; b0 = both_tot; c0 = clk_oe_hi_tot; i0 = inh_tot;

        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        data  = ~d;
        vectors++; if (ps2_clk_oe !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL %s_latency: got clk_oe=%b busy=%b want 1 1", name, ps2_clk_oe, busy); end

        cap_first = '0;
        ok = 1'b1;
        n_dev = (mode == M_NACK) ? ATTEMPTS : 1;
        for (int a = 0; a < n_dev; a++) begin
            device(mode, cap, ok);
            if (a == 0) cap_first = cap;
            if (!ok) break;
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL %s_rts: got no request-to-send want RTS within bound", name); end

        t = 0;
        while (done_tot == d0 && err_tot == e0 && t < 3 * int'(TMO + INH + 100)) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        got = exp_q.pop_front();

        if (mode != M_TMO) begin
            vectors++; if (cap_first !== got.frame) begin miscompares++; $display("FAIL %s_frame: got %03h want %03h", name, cap_first, got.frame); end
            vectors++; if (cap_first[9] !== ~^d) begin miscompares++; $display("FAIL %s_parity: got %b want %b", name, cap_first[9], ~^d); end
        end
        vectors++; if (done_tot - d0 !== ((got.code == 2'd0) ? 1 : 0)) begin miscompares++; $display("FAIL %s_done_count: got %0d want %0d", name, done_tot - d0, (got.code == 2'd0) ? 1 : 0); end
        vectors++; if (err_tot - e0 !== ((got.code != 2'd0) ? 1 : 0)) begin miscompares++; $display("FAIL %s_error_count: got %0d want %0d", name, err_tot - e0, (got.code != 2'd0) ? 1 : 0); end
        vectors++; if (err_code !== got.code) begin miscompares++; $display("FAIL %s_err_code: got %0d want %0d", name, err_code, got.code); end
        vectors++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin miscompares++; $display("FAIL %s_idle_after: got busy=%b clk_oe=%b dat_oe=%b want 0 0 0", name, busy, ps2_clk_oe, ps2_dat_oe); end
        vectors++; if (both_tot !== b0) begin miscompares++; $display("FAIL %s_done_and_error: got %0d overlaps want 0", name, both_tot - b0); end
        if (mode == M_ACK) begin
            vectors++; if (clk_oe_hi_tot - c0 !== int'(INH)) begin miscompares++; $display("FAIL %s_inhibit_len: got %0d want %0d", name, clk_oe_hi_tot - c0, INH); end
        end else begin
            vectors++; if (inh_tot - i0 !== ATTEMPTS) begin miscompares++; $display("FAIL %s_attempts: got %0d want %0d", name, inh_tot - i0, ATTEMPTS); end
        end
    endtask

    task automatic test_ack_ed();
        run_tx(8'hED, M_ACK, "ack_ed");
    endtask

    task automatic test_parity();
        run_tx(8'hFF, M_ACK, "par_ff");
        run_tx(8'h00, M_ACK, "par_00");
        run_tx(8'h01, M_ACK, "par_01");
    endtask

    task automatic test_nack();
        run_tx(8'hF4, M_NACK, "nack");
    endtask

    task automatic test_timeout();
        run_tx(8'hFF, M_TMO, "timeout");
    endtask

    // Reset while the device is mid-frame, then a clean transfer.
    task automatic test_reset_mid();
        exp_t        e;
        exp_t        got;
        logic [10:0] cap;
        bit          ok;
        e.frame = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
        e.code  = 2'd0;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        data  = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        device(M_RST5, cap, ok);
        got = exp_q.pop_front();
        vectors++; if (!ok || cap[4:0] !== got.frame[4:0]) begin miscompares++; $display("FAIL rstmid_partial: got ok=%b bits=%02h want ok=1 bits=%02h", ok, cap[4:0], got.frame[4:0]); end
        vectors++; if (ps2_clk_oe !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_send: got clk_oe=%b busy=%b want 0 1", ps2_clk_oe, busy); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_released: got clk_oe=%b dat_oe=%b busy=%b want 0 0 0", ps2_clk_oe, ps2_dat_oe, busy); end
        reset = 1'b0;
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
        run_tx(8'hF4, M_ACK, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_tx(8'hED, M_ACK, "b2b_1");
        run_tx(8'h07, M_ACK, "b2b_2");
    endtask

    initial begin
        test_reset();
        test_ack_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- It is the opposite direction to keyboard_handler, which receives scan codes on the same PS2_CLK/PS2_DAT pair.
- Drives both lines open-drain through active-high pull-low enables, which the top level turns into tri-states.
- Runs the full inhibit / request-to-send / bit-shift / ACK sequence, with a timeout.

Parameters:
- INHIBIT_CYCLES, 6000: clk cycles the PS/2 clock is held low before request-to-send (120 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles with no device falling edge, and maximum wait for line release (15 ms).
- MAX_RETRIES, 2: extra attempts after a failure. Used only with PS2_TX_RETRY_EN.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high.
- start  in  1  request to send; sampled only in IDLE.
- data  in  8  byte to send; latched on an accepted start.
- ps2_clk_in  in  1  raw PS2_CLK pin level.
- ps2_dat_in  in  1  raw PS2_DAT pin level.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  high from the cycle after start is accepted until done or error.
- done  out  1  one-cycle pulse: byte ACKed and lines released.
- error  out  1  one-cycle pulse on final failure.
- err_code  out  2  0 none, 1 timeout, 2 NACK. Holds until the next accepted start.

Behaviour:
- Reset, applied synchronously on any cycle including mid-transfer:
  - state = IDLE.
  - ps2_clk_oe = 0, ps2_dat_oe = 0, so both lines are released on the next edge.
  - busy = 0, done = 0, error = 0, err_code = 0, counters = 0.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
  - A falling edge (fe) is synced clk previous = 1 and current = 0.
  - Every PS/2 decision uses the synced values.
- Parity: odd; parity bit = ~^data_latched.
- Shift register: 11 bits, in order: start 0, d0..d7, parity, stop 1.
- IDLE:
  - Both oe = 0, busy = 0.
  - start = 1 latches data, clears err_code, and goes to INHIBIT.
  - start while not IDLE is ignored.
- INHIBIT:
  - ps2_clk_oe = 1, ps2_dat_oe = 0. Count INHIBIT_CYCLES.
  - On terminal count: ps2_dat_oe = 1 (start bit), and go to RTS.
- RTS: hold dat low with clk still low for 1 cycle, then ps2_clk_oe = 0 and go to SEND with bit_idx = 1.
- SEND:
  - On each fe: ps2_dat_oe = ~shift[bit_idx], then bit_idx++.
  - fe #1..#8 present d0..d7, fe #9 presents parity, fe #10 presents stop (dat released).
  - After fe #10, go to ACK.
- ACK:
  - On the next fe, sample synced dat.
  - dat = 0: ACK, go to RELEASE.
  - dat = 1: NACK, go to FAIL with code 2.
- RELEASE: wait until synced clk = 1 and synced dat = 1, then pulse done for one cycle and go to IDLE.
- Timeout:
  - A timer clears on entering SEND and on every fe in SEND/ACK/RELEASE.
  - Reaching TIMEOUT_CYCLES in SEND, ACK or RELEASE goes to FAIL with code 1.
- FAIL:
  - Both oe = 0, err_code set, error pulse for one cycle, then IDLE.
  - The retry feature can redirect this (see Optional Feature).
- done and error are never high in the same cycle.
- Latency: an accepted start to ps2_clk_oe rising is 1 cycle.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- When defined:
  - FAIL re-enters INHIBIT with the same latched byte while retry_cnt < MAX_RETRIES, and increments retry_cnt.
  - No error pulse is given on intermediate failures. busy stays high.
  - error pulses only after attempt MAX_RETRIES+1 fails. err_code reflects the last failure.
  - retry_cnt clears on an accepted start.
- When undefined: the first failure gives the error pulse. No retry logic is synthesized.

Test Plan:
- Reset, then idle 100 cycles -> both oe = 0, busy = 0, done = 0, error = 0, err_code = 0.
- start with data = 0xED; the device model clocks at 12 kHz and ACKs:
  - ps2_clk_oe is high for exactly 6000 cycles.
  - The model captures bits 0,1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - done pulses once after the lines release; busy then falls.
- data = 0xFF with ACK -> parity bit = 1 captured; done. data = 0x00 -> parity = 1; data = 0x01 -> parity = 0.
- The device model NACKs (dat high at the ACK clock) -> error pulses once, err_code = 2, no done, both oe = 0.
- The device model never clocks after RTS -> error after 750000 idle cycles, err_code = 1. With PS2_TX_RETRY_EN: 3 INHIBIT phases seen, one error pulse.
- Reset asserted at fe #5 of SEND -> both oe = 0 and state IDLE the next cycle. A new start = 0xF4 then completes with done.
